// File: rtl/jtag_seq_master.sv
// Clock-driven JTAG master: executes TAP reset, TMS sequences, scans and run-idle
// commands, streaming TMS/TDI bits from tx words and TDO bits into rx words.
module jtag_seq_master #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_RESET   = 3'd0;
  localparam logic [2:0] OP_TMS_SEQ = 3'd1;
  localparam logic [2:0] OP_SCAN    = 3'd2;
  localparam logic [2:0] OP_FLIP    = 3'd3;
  localparam logic [2:0] OP_RUNIDLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_PUSH,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        op_q;
  logic [LEN_W-1:0]  len_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  hcnt;
  logic [LEN_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_sh;
  logic              tms_q;
  logic              tdi_q;

  logic              has_tx;
  logic              is_scan;
  logic              half_done;
  logic              word_end;
  logic              last_bit;
  logic              rx_hold;
  logic [LEN_W-1:0]  bit_inc;
  logic [IDX_W-1:0]  widx_inc;

  logic              enter_low;
  logic              push_go;
  logic [2:0]        nb_op;
  logic [LEN_W-1:0]  nb_idx;
  logic [IDX_W-1:0]  nb_widx;
  logic [DATA_W-1:0] nb_word;
  logic              nb_tms;
  logic              nb_tdi;

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= OP_RUNIDLE);
  endfunction

  // Pin values {tms, tdi} for bit idx of a command; wbit is the tx word bit.
  function automatic logic [1:0] bit_drive(input logic [2:0]       op,
                                           input logic [LEN_W-1:0] idx,
                                           input logic [LEN_W-1:0] len,
                                           input logic             wbit);
    case (op)
      OP_RESET:   bit_drive = {(idx != LEN_W'(5)), 1'b0};
      OP_TMS_SEQ: bit_drive = {wbit, 1'b0};
      OP_SCAN:    bit_drive = {1'b0, wbit};
      OP_FLIP:    bit_drive = {(idx == len - 1'b1), wbit};
      default:    bit_drive = 2'b00;
    endcase
  endfunction

  assign has_tx    = (op_q == OP_TMS_SEQ) || (op_q == OP_SCAN) || (op_q == OP_FLIP);
  assign is_scan   = (op_q == OP_SCAN) || (op_q == OP_FLIP);
  assign half_done = (hcnt == div_q);
  assign word_end  = (widx == IDX_W'(DATA_W - 1));
  assign bit_inc   = bit_cnt + 1'b1;
  assign last_bit  = (bit_inc == len_q);
  assign widx_inc  = word_end ? '0 : widx + 1'b1;
  assign rx_hold   = rx_valid & ~rx_ready;

  always_comb begin
    state_nxt = state;
    enter_low = 1'b0;
    push_go   = 1'b0;
    nb_op     = op_q;
    nb_idx    = bit_cnt;
    nb_widx   = widx;
    nb_word   = tx_word;
    unique case (state)
      S_IDLE: begin
        nb_op   = cmd_op;
        nb_idx  = '0;
        nb_widx = '0;
        if (cmd_valid) begin
          if (!op_legal(cmd_op)) begin
            state_nxt = S_FIN;
          end else if ((cmd_op != OP_RESET) && (cmd_len == '0)) begin
            state_nxt = S_FIN;
          end else if ((cmd_op == OP_TMS_SEQ) || (cmd_op == OP_SCAN) || (cmd_op == OP_FLIP)) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_LOW;
            enter_low = 1'b1;
          end
        end
      end
      S_LOAD: begin
        nb_word = tx_data;
        if (tx_valid) begin
          state_nxt = S_LOW;
          enter_low = 1'b1;
        end
      end
      S_LOW: begin
        if (half_done) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        nb_idx  = bit_inc;
        nb_widx = widx_inc;
        if (half_done) begin
          if (is_scan && (word_end || last_bit)) begin
            state_nxt = S_PUSH;
          end else if (last_bit) begin
            state_nxt = S_FIN;
          end else if (has_tx && word_end) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_LOW;
            enter_low = 1'b1;
          end
        end
      end
      S_PUSH: begin
        // bit_cnt/widx already point at the next bit here
        if (!rx_hold) begin
          push_go = 1'b1;
          if (bit_cnt == len_q) begin
            state_nxt = S_FIN;
          end else if (has_tx && (widx == '0)) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_LOW;
            enter_low = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    {nb_tms, nb_tdi} = bit_drive(nb_op, nb_idx, len_q, nb_word[nb_widx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      len_q    <= '0;
      div_q    <= '0;
      hcnt     <= '0;
      bit_cnt  <= '0;
      widx     <= '0;
      tx_word  <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE) && cmd_valid) begin
        op_q    <= cmd_op;
        len_q   <= (cmd_op == OP_RESET) ? LEN_W'(6) : cmd_len;
        div_q   <= cmd_div;
        bit_cnt <= '0;
        widx    <= '0;
        rx_sh   <= '0;
      end

      if ((state == S_LOAD) && tx_valid) tx_word <= tx_data;

      // pins only move on LOW entry, and are parked low for FIN
      if (enter_low) begin
        tms_q <= nb_tms;
        tdi_q <= nb_tdi;
      end
      if (state_nxt == S_FIN) begin
        tms_q <= 1'b0;
        tdi_q <= 1'b0;
      end

      // half-period timer restarts on every state change; stalls never advance it
      if (state_nxt != state) begin
        hcnt <= '0;
      end else if ((state == S_LOW) || (state == S_HIGH)) begin
        hcnt <= hcnt + 1'b1;
      end

      if ((state == S_HIGH) && (hcnt == '0) && is_scan) rx_sh[widx] <= tdo;

      if ((state == S_HIGH) && half_done) begin
        bit_cnt <= bit_inc;
        widx    <= widx_inc;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (push_go) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
        rx_sh    <= '0;
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign tx_ready  = (state == S_LOAD);
  assign tck       = (state == S_HIGH);
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign done      = (state == S_FIN);
  assign err       = (state == S_FIN) && !op_legal(op_q);

endmodule
